pakout_arbiter: RTL and testbench

//  Round-robin arbiter sharing one outbound message channel among NUM_IN message sources.

---
 rtl/pakout_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_pakout_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pakout_arbiter.sv
// Round-robin arbiter: shares one outbound message channel among NUM_IN sources.
// Latches the granted message, replays it on the shared channel, then acks the source.
module pakout_arbiter #(
    parameter int  NUM_IN  = 4,
    parameter int  ASZ     = 6,
    parameter int  DSZ     = 4,
    parameter int  RSZ     = 4,
    parameter int  ACK_CKS = 2,
    localparam int IDXW    = $clog2(NUM_IN)
) (
    input  logic                  src_clk,
    input  logic                  reset,
    input  logic [NUM_IN-1:0]     i_req_in,
    output logic [NUM_IN-1:0]     i_ack_out,
    input  logic [NUM_IN*ASZ-1:0] i_src,
    input  logic [NUM_IN*ASZ-1:0] i_dst,
    input  logic [NUM_IN*DSZ-1:0] i_dat,
    input  logic [NUM_IN*RSZ-1:0] i_red,
    output logic                  o_req_out,
    input  logic                  o_ack_in,
    output logic [ASZ-1:0]        o_src,
    output logic [ASZ-1:0]        o_dst,
    output logic [DSZ-1:0]        o_dat,
    output logic [RSZ-1:0]        o_red,
    output logic                  busy,
    output logic [IDXW-1:0]       grant_idx,
    output logic                  proto_err,
    output logic [15:0]           msg_cnt
);

    localparam int CW = $clog2(ACK_CKS + 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_ACK, WAIT_REL} state_t;

    state_t            state, state_d;
    logic [IDXW-1:0]   rr_ptr, rr_d, grant_d, sel_idx;
    logic              sel_found;
    logic [ASZ-1:0]    sel_src, sel_dst, src_d, dst_d;
    logic [DSZ-1:0]    sel_dat, dat_d;
    logic [RSZ-1:0]    sel_red, red_d;
    logic              req_d, err_d, req_k;
    logic [NUM_IN-1:0] ack_out_d;
    logic [15:0]       cnt_d;
    logic              ack_lvl, ack_hi, ack_lo;
    logic [CW-1:0]     ack_run, run_now;

    // Length of the current o_ack_in run including this cycle; any level change restarts it.
    always_comb begin
        if (o_ack_in != ack_lvl)
            run_now = CW'(1);
        else if (ack_run == CW'(ACK_CKS))
            run_now = ack_run;
        else
            run_now = ack_run + CW'(1);
    end

    assign ack_hi = o_ack_in && (run_now == CW'(ACK_CKS));
    assign ack_lo = !o_ack_in && (run_now == CW'(ACK_CKS));
    assign req_k  = i_req_in[grant_idx];
    assign busy   = (state != IDLE);

    always_comb begin : rr_select
        int j;
        j         = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_src   = '0;
        sel_dst   = '0;
        sel_dat   = '0;
        sel_red   = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NUM_IN)
                j = j - NUM_IN;
            if (!sel_found && i_req_in[j]) begin
                sel_found = 1'b1;
                sel_idx   = IDXW'(j);
            end
        end
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel_idx == IDXW'(k)) begin
                sel_src = i_src[k*ASZ +: ASZ];
                sel_dst = i_dst[k*ASZ +: ASZ];
                sel_dat = i_dat[k*DSZ +: DSZ];
                sel_red = i_red[k*RSZ +: RSZ];
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets its hold value first so no path can infer a latch.
        state_d   = state;
        req_d     = o_req_out;
        ack_out_d = i_ack_out;
        grant_d   = grant_idx;
        rr_d      = rr_ptr;
        cnt_d     = msg_cnt;
        err_d     = proto_err;
        src_d     = o_src;
        dst_d     = o_dst;
        dat_d     = o_dat;
        red_d     = o_red;
        case (state)
            IDLE: begin
                if (sel_found && (i_ack_out == '0)) begin
                    grant_d = sel_idx;
                    src_d   = sel_src;
                    dst_d   = sel_dst;
                    dat_d   = sel_dat;
                    red_d   = sel_red;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (!req_k) begin
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = WAIT_REL;
                end else begin
                    req_d   = 1'b1;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (!req_k) begin
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = WAIT_REL;
                end else if (ack_hi) begin
                    req_d                = 1'b0;
                    ack_out_d[grant_idx] = 1'b1;
                    state_d              = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (!req_k && ack_lo) begin
                    ack_out_d = '0;
                    rr_d      = (grant_idx == IDXW'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;
                    // A raised ack marks a completed transfer; aborts leave it low.
                    if (i_ack_out[grant_idx] && (msg_cnt != 16'hFFFF))
                        cnt_d = msg_cnt + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge src_clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            ack_lvl   <= 1'b0;
            ack_run   <= '0;
            o_req_out <= 1'b0;
            i_ack_out <= '0;
            grant_idx <= '0;
            msg_cnt   <= '0;
            proto_err <= 1'b0;
            o_src     <= '0;
            o_dst     <= '0;
            o_dat     <= '0;
            o_red     <= '0;
        end else begin
            // NOTE: non-blocking updates so all state advances together on the edge.
            state     <= state_d;
            rr_ptr    <= rr_d;
            ack_lvl   <= o_ack_in;
            ack_run   <= run_now;
            o_req_out <= req_d;
            i_ack_out <= ack_out_d;
            grant_idx <= grant_d;
            msg_cnt   <= cnt_d;
            proto_err <= err_d;
            o_src     <= src_d;
            o_dst     <= dst_d;
            o_dat     <= dat_d;
            o_red     <= red_d;
        end
    end

endmodule

// File: tb/tb_pakout_arbiter.sv
// Bench for pakout_arbiter: table-driven transfers plus hand-written corner sequences,
// with a scoreboard comparing each message as it appears on the shared channel.
module tb_pakout_arbiter;

    localparam int NUM_IN  = 4;
    localparam int ASZ     = 6;
    localparam int DSZ     = 4;
    localparam int RSZ     = 4;
    localparam int ACK_CKS = 2;
    localparam int IDXW    = 2;

    logic                  src_clk = 1'b0;
    logic                  reset   = 1'b1;
    logic [NUM_IN-1:0]     i_req_in = '0;
    logic [NUM_IN-1:0]     i_ack_out;
    logic [NUM_IN*ASZ-1:0] i_src, i_dst;
    logic [NUM_IN*DSZ-1:0] i_dat;
    logic [NUM_IN*RSZ-1:0] i_red;
    logic                  o_req_out;
    logic                  o_ack_in = 1'b0;
    logic [ASZ-1:0]        o_src, o_dst;
    logic [DSZ-1:0]        o_dat;
    logic [RSZ-1:0]        o_red;
    logic                  busy;
    logic [IDXW-1:0]       grant_idx;
    logic                  proto_err;
    logic [15:0]           msg_cnt;

    logic [ASZ-1:0] f_src [NUM_IN];
    logic [ASZ-1:0] f_dst [NUM_IN];
    logic [DSZ-1:0] f_dat [NUM_IN];
    logic [RSZ-1:0] f_red [NUM_IN];

    typedef struct {
        logic [IDXW-1:0] idx;
        logic [ASZ-1:0]  src;
        logic [ASZ-1:0]  dst;
        logic [DSZ-1:0]  dat;
        logic [RSZ-1:0]  red;
    } exp_t;

    typedef struct {
        logic [NUM_IN-1:0] mask;
        int                idx;
        int                rr_after;
        int                ack_dly;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[8];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;
    logic req_q    = 1'b0;

    pakout_arbiter #(
        .NUM_IN(NUM_IN), .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ), .ACK_CKS(ACK_CKS)
    ) dut (
        .src_clk(src_clk), .reset(reset),
        .i_req_in(i_req_in), .i_ack_out(i_ack_out),
        .i_src(i_src), .i_dst(i_dst), .i_dat(i_dat), .i_red(i_red),
        .o_req_out(o_req_out), .o_ack_in(o_ack_in),
        .o_src(o_src), .o_dst(o_dst), .o_dat(o_dat), .o_red(o_red),
        .busy(busy), .grant_idx(grant_idx), .proto_err(proto_err), .msg_cnt(msg_cnt)
    );

    always #5 src_clk = ~src_clk;

    always_comb begin
        for (int k = 0; k < NUM_IN; k++) begin
            i_src[k*ASZ +: ASZ] = f_src[k];
            i_dst[k*ASZ +: ASZ] = f_dst[k];
            i_dat[k*DSZ +: DSZ] = f_dat[k];
            i_red[k*RSZ +: RSZ] = f_red[k];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return o_req_out;
            1:       return |i_ack_out;
            default: return busy;
        endcase
    endfunction

    // Poll on falling edges until the selected signal reaches val, or the budget runs out.
    task automatic wait_until(input int sel, input logic val, input int budget, input string name);
        int n = 0;
        while (sig(sel) !== val && n < budget) begin
            @(negedge src_clk);
            n++;
        end
        check(name, 32'(sig(sel)), 32'(val));
    endtask

    task automatic set_fields();
        for (int k = 0; k < NUM_IN; k++) begin
            f_src[k] = ASZ'($urandom);
            f_dst[k] = ASZ'($urandom);
            f_dat[k] = DSZ'($urandom);
            f_red[k] = RSZ'($urandom);
        end
    endtask

    task automatic push_exp(input int k);
        sb.push_back('{idx: IDXW'(k), src: f_src[k], dst: f_dst[k], dat: f_dat[k], red: f_red[k]});
    endtask

    // Scoreboard: each rise of o_req_out must carry the next expected message.
    always @(negedge src_clk) begin
        if (o_req_out && !req_q) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_req", 32'(o_req_out), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_grant", 32'(grant_idx), 32'(mon_e.idx));
                check("sb_src", 32'(o_src), 32'(mon_e.src));
                check("sb_dst", 32'(o_dst), 32'(mon_e.dst));
                check("sb_dat", 32'(o_dat), 32'(mon_e.dat));
                check("sb_red", 32'(o_red), 32'(mon_e.red));
            end
        end
        req_q = o_req_out;
    end

    task automatic do_xfer(input vec_t v);
        logic [DSZ-1:0] kept_dat;
        set_fields();
        i_req_in = v.mask;
        push_exp(v.idx);
        kept_dat = f_dat[v.idx];
        wait_until(0, 1'b1, 8, "xfer_req_rise");
        set_fields();
        repeat (v.ack_dly) @(negedge src_clk);
        o_ack_in = 1'b1;
        wait_until(1, 1'b1, 8, "xfer_ack_rise");
        check("xfer_ack_onehot", 32'(i_ack_out), 32'(1 << v.idx));
        check("xfer_req_drop", 32'(o_req_out), 32'd0);
        check("xfer_dat_held", 32'(o_dat), 32'(kept_dat));
        i_req_in = '0;
        o_ack_in = 1'b0;
        wait_until(2, 1'b0, 8, "xfer_idle");
        exp_cnt++;
        check("xfer_msg_cnt", 32'(msg_cnt), 32'(exp_cnt));
        check("xfer_rr_ptr", 32'(dut.rr_ptr), 32'(v.rr_after));
        check("xfer_ack_clear", 32'(i_ack_out), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        vecs[0] = '{mask: 4'b1010, idx: 3, rr_after: 0, ack_dly: 0};
        vecs[1] = '{mask: 4'b1010, idx: 1, rr_after: 2, ack_dly: 1};
        vecs[2] = '{mask: 4'b0011, idx: 0, rr_after: 1, ack_dly: 2};
        vecs[3] = '{mask: 4'b1001, idx: 3, rr_after: 0, ack_dly: 3};
        vecs[4] = '{mask: 4'b0110, idx: 1, rr_after: 2, ack_dly: 0};
        vecs[5] = '{mask: 4'b0001, idx: 0, rr_after: 1, ack_dly: 1};
        vecs[6] = '{mask: 4'b1111, idx: 1, rr_after: 2, ack_dly: 2};
        vecs[7] = '{mask: 4'b0101, idx: 2, rr_after: 3, ack_dly: 0};
        set_fields();

        // Reset state
        repeat (3) @(negedge src_clk);
        check("rst_req_out", 32'(o_req_out), 32'd0);
        check("rst_ack_out", 32'(i_ack_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_msg_cnt", 32'(msg_cnt), 32'd0);
        check("rst_o_dat", 32'(o_dat), 32'd0);
        check("rst_rr_ptr", 32'(dut.rr_ptr), 32'd0);
        reset = 1'b0;
        @(negedge src_clk);

        // T1: single transfer from source 2, exact latencies
        set_fields();
        f_src[2] = 6'h2A;
        f_dst[2] = 6'd5;
        f_dat[2] = 4'd9;
        f_red[2] = 4'd3;
        i_req_in = 4'b0100;
        push_exp(2);
        @(negedge src_clk);
        check("t1_req_lat1", 32'(o_req_out), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_grant", 32'(grant_idx), 32'd2);
        check("t1_dst_early", 32'(o_dst), 32'd5);
        @(negedge src_clk);
        check("t1_req_lat2", 32'(o_req_out), 32'd1);
        repeat (3) @(negedge src_clk);
        o_ack_in = 1'b1;
        @(negedge src_clk);
        check("t1_ack_filtered", 32'(i_ack_out), 32'd0);
        check("t1_req_held", 32'(o_req_out), 32'd1);
        @(negedge src_clk);
        check("t1_ack_out", 32'(i_ack_out), 32'b0100);
        check("t1_dat", 32'(o_dat), 32'd9);
        check("t1_red", 32'(o_red), 32'd3);
        i_req_in = '0;
        o_ack_in = 1'b0;
        wait_until(2, 1'b0, 8, "t1_idle");
        exp_cnt = 1;
        check("t1_msg_cnt", 32'(msg_cnt), 32'd1);
        check("t1_rr_ptr", 32'(dut.rr_ptr), 32'd3);

        // Table-driven transfers (covers T3 wrap/priority in the first two rows)
        foreach (vecs[i]) do_xfer(vecs[i]);

        // T4: one-cycle ack glitch is ignored, two-cycle ack accepted
        set_fields();
        i_req_in = 4'b1000;
        push_exp(3);
        wait_until(0, 1'b1, 8, "t4_req_rise");
        o_ack_in = 1'b1;
        @(negedge src_clk);
        o_ack_in = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge src_clk);
            check("t4_req_stays", 32'(o_req_out), 32'd1);
            check("t4_no_ack", 32'(i_ack_out), 32'd0);
        end
        o_ack_in = 1'b1;
        @(negedge src_clk);
        check("t4_ack_first", 32'(i_ack_out), 32'd0);
        @(negedge src_clk);
        check("t4_ack_second", 32'(i_ack_out), 32'b1000);
        i_req_in = '0;
        o_ack_in = 1'b0;
        wait_until(2, 1'b0, 8, "t4_idle");
        exp_cnt++;
        check("t4_msg_cnt", 32'(msg_cnt), 32'(exp_cnt));
        check("t4_rr_ptr", 32'(dut.rr_ptr), 32'd0);

        // T5: source 0 aborts in WAIT_ACK
        check("t5_err_before", 32'(proto_err), 32'd0);
        set_fields();
        i_req_in = 4'b0001;
        push_exp(0);
        wait_until(0, 1'b1, 8, "t5_req_rise");
        i_req_in = '0;
        @(negedge src_clk);
        check("t5_proto_err", 32'(proto_err), 32'd1);
        check("t5_req_drop", 32'(o_req_out), 32'd0);
        check("t5_no_ack", 32'(i_ack_out), 32'd0);
        wait_until(2, 1'b0, 8, "t5_idle");
        check("t5_no_ack_after", 32'(i_ack_out), 32'd0);
        check("t5_msg_cnt", 32'(msg_cnt), 32'(exp_cnt));
        check("t5_rr_ptr", 32'(dut.rr_ptr), 32'd1);
        do_xfer('{mask: 4'b0010, idx: 1, rr_after: 2, ack_dly: 1});
        check("t5_err_sticky", 32'(proto_err), 32'd1);

        // T6: asynchronous reset during WAIT_REL
        set_fields();
        i_req_in = 4'b0100;
        push_exp(2);
        wait_until(0, 1'b1, 8, "t6_req_rise");
        o_ack_in = 1'b1;
        wait_until(1, 1'b1, 8, "t6_ack_rise");
        @(negedge src_clk);
        check("t6_ack_held", 32'(i_ack_out), 32'b0100);
        reset = 1'b1;
        #1;
        check("t6_ack_out", 32'(i_ack_out), 32'd0);
        check("t6_req_out", 32'(o_req_out), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_msg_cnt", 32'(msg_cnt), 32'd0);
        check("t6_proto_err", 32'(proto_err), 32'd0);
        i_req_in = '0;
        o_ack_in = 1'b0;
        @(negedge src_clk);
        reset = 1'b0;
        exp_cnt = 0;
        @(negedge src_clk);

        // T2: all sources requesting continuously, eight transfers
        set_fields();
        i_req_in = '1;
        for (int n = 0; n < 8; n++) push_exp(n % NUM_IN);
        for (int n = 0; n < 8; n++) begin
            k = n % NUM_IN;
            wait_until(0, 1'b1, 12, "t2_req_rise");
            o_ack_in = 1'b1;
            wait_until(1, 1'b1, 8, "t2_ack_rise");
            check("t2_grant_seq", 32'(grant_idx), 32'(k));
            check("t2_ack_onehot", 32'(i_ack_out), 32'(1 << k));
            i_req_in[k] = 1'b0;
            o_ack_in = 1'b0;
            wait_until(2, 1'b0, 8, "t2_idle");
            i_req_in[k] = 1'b1;
            exp_cnt++;
        end
        i_req_in = '0;
        repeat (3) @(negedge src_clk);
        check("t2_msg_cnt", 32'(msg_cnt), 32'(exp_cnt));
        check("t2_busy_end", 32'(busy), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
